// File: rtl/leaf_out_arbiter.sv
// Burst-locked round-robin arbiter sharing one leaf_interface output port among NUM_REQ streams.
// Define LEAF_ARB_HDR_EN to prefix every grant with a 0xC0DE header word carrying the owner index.
module leaf_out_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int IDX_BITS     = 2,
  parameter int BURST_LEN    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         dout,
  output logic                            dout_vld,
  input  logic                            dout_ack,
  output logic [IDX_BITS-1:0]             grant_idx,
  output logic                            busy
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t                  state_q;
  logic [IDX_BITS-1:0]     rrPtr_q;
  logic [IDX_BITS-1:0]     owner_q;
  logic [CNT_W-1:0]        beatCnt_q;
  logic                    busy_q;
  logic [IDX_BITS-1:0]     grantIdx_q;

  logic                    anyReq;
  logic [IDX_BITS-1:0]     pickIdx;
  logic [IDX_BITS-1:0]     nextPtr;
  logic                    ownerVld;
  logic                    ownerXfer;
  logic                    burstDone;
  logic [PAYLOAD_BITS-1:0] ownerData;

  assign ownerVld  = req_vld[owner_q];
  assign ownerData = req_din[int'(owner_q)*PAYLOAD_BITS +: PAYLOAD_BITS];
  assign ownerXfer = reset && (state_q == GRANT) && ownerVld && dout_ack;
  assign burstDone = ownerXfer && (beatCnt_q == LAST_BEAT);
  assign nextPtr   = (owner_q == IDX_BITS'(NUM_REQ - 1)) ? '0 : owner_q + IDX_BITS'(1);

`ifdef LEAF_ARB_HDR_EN
  logic [PAYLOAD_BITS-1:0] hdrWord;
  assign hdrWord = {16'hC0DE, (PAYLOAD_BITS-16)'(owner_q)};
`endif

  // First requester at or after rrPtr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int cand;
    cand    = 0;
    anyReq  = 1'b0;
    pickIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rrPtr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!anyReq && req_vld[cand]) begin
        anyReq  = 1'b1;
        pickIdx = IDX_BITS'(cand);
      end
    end
  end

  // Port mux is combinational so a granted word costs no extra cycle; gated off while reset is low.
  always_comb begin
    dout     = '0;
    dout_vld = 1'b0;
    req_ack  = '0;
    if (reset) begin
      case (state_q)
        GRANT: begin
          dout             = ownerData;
          dout_vld         = ownerVld;
          req_ack[owner_q] = ownerVld & dout_ack;
        end
`ifdef LEAF_ARB_HDR_EN
        HDR: begin
          dout     = hdrWord;
          dout_vld = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      owner_q    <= '0;
      beatCnt_q  <= '0;
      busy_q     <= 1'b0;
      grantIdx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            owner_q    <= pickIdx;
            grantIdx_q <= pickIdx;
            busy_q     <= 1'b1;
            beatCnt_q  <= '0;
`ifdef LEAF_ARB_HDR_EN
            state_q    <= HDR;
`else
            state_q    <= GRANT;
`endif
          end
        end
`ifdef LEAF_ARB_HDR_EN
        HDR: begin
          if (dout_ack) state_q <= GRANT;
        end
`endif
        GRANT: begin
          // An idle owner gives up the port at once; there is no hold-off timer.
          if (burstDone || !ownerVld) begin
            state_q    <= IDLE;
            rrPtr_q    <= nextPtr;
            beatCnt_q  <= '0;
            busy_q     <= 1'b0;
            grantIdx_q <= '0;
          end else if (ownerXfer) begin
            beatCnt_q <= beatCnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign grant_idx = grantIdx_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: a per-cycle table for single-stream handshakes plus scoreboarded
// multi-stream bursts, rotation timing, reset abort and (with LEAF_ARB_HDR_EN) header framing.
module tb_leaf_out_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int PB        = 32;
  localparam int IDX_BITS  = 2;
  localparam int BURST_LEN = 16;
`ifdef LEAF_ARB_HDR_EN
  localparam int HDR_BEATS = 1;
`else
  localparam int HDR_BEATS = 0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_REQ*PB-1:0]  req_din;
  logic [NUM_REQ-1:0]     req_vld;
  logic [NUM_REQ-1:0]     req_ack;
  logic [PB-1:0]          dout;
  logic                   dout_vld;
  logic                   dout_ack;
  logic [IDX_BITS-1:0]    grant_idx;
  logic                   busy;

  leaf_out_arbiter #(
    .NUM_REQ(NUM_REQ), .PAYLOAD_BITS(PB), .IDX_BITS(IDX_BITS), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .reset(reset), .req_din(req_din), .req_vld(req_vld), .req_ack(req_ack),
    .dout(dout), .dout_vld(dout_vld), .dout_ack(dout_ack), .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic                hdr;
    logic [PB-1:0]       data;
  } exp_t;

  typedef struct {
    logic [NUM_REQ-1:0]    vld;
    logic [NUM_REQ*PB-1:0] din;
    logic                  ack;
    logic                  expVld;
    logic [PB-1:0]         expDout;
    logic [NUM_REQ-1:0]    expAck;
    logic                  expBusy;
    logic [IDX_BITS-1:0]   expIdx;
  } row_t;

  exp_t               expQ[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 cycleNum = 0;
  int                 seq[NUM_REQ];
  int                 left[NUM_REQ];
  logic [NUM_REQ-1:0] ackSeen;
  bit                 autoEn;
  int                 firstXfer;
  int                 lastXfer;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PB-1:0] srcWord(input int i, input int s);
    return PB'(((i + 1) << 16) | (s & 16'hFFFF));
  endfunction

  task automatic setSources(input int l0, input int l1, input int l2, input int l3);
    for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
    left[0] = l0; left[1] = l1; left[2] = l2; left[3] = l3;
    ackSeen = '0;
    autoEn  = 1'b1;
  endtask

  task automatic driveSources();
    if (autoEn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_vld[i]            = (left[i] > 0);
        req_din[i*PB +: PB]   = srcWord(i, seq[i]);
      end
    end
  endtask

  task automatic advanceSources();
    if (autoEn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ackSeen[i]) begin
          seq[i]++;
          left[i]--;
        end
      end
    end
    ackSeen = '0;
  endtask

  task automatic pushBurst(input int idx, input int startSeq, input int n);
    exp_t e;
`ifdef LEAF_ARB_HDR_EN
    e.idx  = IDX_BITS'(idx);
    e.hdr  = 1'b1;
    e.data = {16'hC0DE, 16'(idx)};
    expQ.push_back(e);
`endif
    for (int k = 0; k < n; k++) begin
      e.idx  = IDX_BITS'(idx);
      e.hdr  = 1'b0;
      e.data = srcWord(idx, startSeq + k);
      expQ.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t               e;
    logic [NUM_REQ-1:0] expAck;
    ackSeen = req_ack;
    if (dout_vld && dout_ack) begin
      if (firstXfer < 0) firstXfer = cycleNum;
      lastXfer = cycleNum;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_xfer: got dout=%0h idx=%0d, expected no transfer", dout, grant_idx);
      end else begin
        e = expQ.pop_front();
        expAck = '0;
        if (!e.hdr) expAck[e.idx] = 1'b1;
        checkOutput("xfer_data", dout, e.data);
        checkOutput("xfer_idx", grant_idx, e.idx);
        checkOutput("xfer_ack", req_ack, expAck);
      end
    end else begin
      checkOutput("no_xfer_ack", req_ack, '0);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    advanceSources();
    driveSources();
  endtask

  task automatic runUntilDrained(input string name, input int budget);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput({name, "_drained"}, expQ.size(), 0);
    if (expQ.size() > 0) expQ.delete();
  endtask

  function automatic row_t mkRow(input logic [3:0] vld, input logic [31:0] d3, input logic [31:0] d2,
                                 input logic [31:0] d1, input logic ack, input logic eVld,
                                 input logic [31:0] eDout, input logic [3:0] eAck, input logic eBusy,
                                 input logic [1:0] eIdx);
    row_t r;
    r.vld = vld; r.din = {d3, d2, d1, 32'h0}; r.ack = ack;
    r.expVld = eVld; r.expDout = eDout; r.expAck = eAck; r.expBusy = eBusy; r.expIdx = eIdx;
    return r;
  endfunction

  task automatic applyStimulus(input row_t r);
    req_vld  = r.vld;
    req_din  = r.din;
    dout_ack = r.ack;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifndef LEAF_ARB_HDR_EN
    row_t tbl[17];
`endif
    reset     = 1'b0;
    dout_ack  = 1'b1;
    req_vld   = '0;
    req_din   = '0;
    firstXfer = -1;
    lastXfer  = -1;
    setSources(32, 16, 16, 16);
    driveSources();

    // Reset held with every stream requesting: everything stays quiet.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("reset_outputs_c%0d", c), {req_ack, dout, dout_vld, grant_idx, busy}, '0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;

    // All streams always valid: 16-word bursts rotating 0,1,2,3,0 with one idle cycle between.
    pushBurst(0, 0, 16);
    pushBurst(1, 0, 16);
    pushBurst(2, 0, 16);
    pushBurst(3, 0, 16);
    pushBurst(0, 16, 16);
    runUntilDrained("rotation", 300);
    checkOutput("rotation_span", lastXfer - firstXfer + 1, 5 * (BURST_LEN + HDR_BEATS) + 4);
    repeat (3) stepCycle();

`ifndef LEAF_ARB_HDR_EN
    // Single-stream handshakes: stream 2 streams five words, stream 1 under ack stalls, then rr check.
    tbl[0]  = mkRow(4'b0100, 32'h0,   32'h100, 32'h0,   1'b1, 1'b0, 32'h0,   4'b0000, 1'b0, 2'd0);
    tbl[1]  = mkRow(4'b0100, 32'h0,   32'h100, 32'h0,   1'b1, 1'b1, 32'h100, 4'b0100, 1'b1, 2'd2);
    tbl[2]  = mkRow(4'b0100, 32'h0,   32'h101, 32'h0,   1'b1, 1'b1, 32'h101, 4'b0100, 1'b1, 2'd2);
    tbl[3]  = mkRow(4'b0100, 32'h0,   32'h102, 32'h0,   1'b1, 1'b1, 32'h102, 4'b0100, 1'b1, 2'd2);
    tbl[4]  = mkRow(4'b0100, 32'h0,   32'h103, 32'h0,   1'b1, 1'b1, 32'h103, 4'b0100, 1'b1, 2'd2);
    tbl[5]  = mkRow(4'b0100, 32'h0,   32'h104, 32'h0,   1'b1, 1'b1, 32'h104, 4'b0100, 1'b1, 2'd2);
    tbl[6]  = mkRow(4'b0000, 32'h0,   32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   4'b0000, 1'b1, 2'd2);
    tbl[7]  = mkRow(4'b0000, 32'h0,   32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   4'b0000, 1'b0, 2'd0);
    tbl[8]  = mkRow(4'b0010, 32'h0,   32'h0,   32'h200, 1'b1, 1'b0, 32'h0,   4'b0000, 1'b0, 2'd0);
    tbl[9]  = mkRow(4'b0010, 32'h0,   32'h0,   32'h200, 1'b1, 1'b1, 32'h200, 4'b0010, 1'b1, 2'd1);
    tbl[10] = mkRow(4'b0010, 32'h0,   32'h0,   32'h201, 1'b0, 1'b1, 32'h201, 4'b0000, 1'b1, 2'd1);
    tbl[11] = mkRow(4'b0010, 32'h0,   32'h0,   32'h201, 1'b0, 1'b1, 32'h201, 4'b0000, 1'b1, 2'd1);
    tbl[12] = mkRow(4'b0010, 32'h0,   32'h0,   32'h201, 1'b1, 1'b1, 32'h201, 4'b0010, 1'b1, 2'd1);
    tbl[13] = mkRow(4'b0010, 32'h0,   32'h0,   32'h202, 1'b1, 1'b1, 32'h202, 4'b0010, 1'b1, 2'd1);
    tbl[14] = mkRow(4'b0000, 32'h0,   32'h0,   32'h202, 1'b1, 1'b0, 32'h202, 4'b0000, 1'b1, 2'd1);
    tbl[15] = mkRow(4'b1010, 32'h300, 32'h0,   32'h202, 1'b0, 1'b0, 32'h0,   4'b0000, 1'b0, 2'd0);
    tbl[16] = mkRow(4'b1010, 32'h300, 32'h0,   32'h202, 1'b0, 1'b1, 32'h300, 4'b0000, 1'b1, 2'd3);
    autoEn = 1'b0;
    for (int r = 0; r < 17; r++) begin
      applyStimulus(tbl[r]);
      @(negedge clk);
      checkOutput($sformatf("row%0d_dout_vld", r), dout_vld, tbl[r].expVld);
      checkOutput($sformatf("row%0d_dout", r), dout, tbl[r].expDout);
      checkOutput($sformatf("row%0d_req_ack", r), req_ack, tbl[r].expAck);
      checkOutput($sformatf("row%0d_busy", r), busy, tbl[r].expBusy);
      checkOutput($sformatf("row%0d_grant_idx", r), grant_idx, tbl[r].expIdx);
      @(posedge clk);
      #1;
    end
    dout_ack = 1'b1;
    setSources(0, 0, 0, 0);
    driveSources();
    repeat (2) stepCycle();
`endif

    // Reset during stream 1's burst after 7 words; pointer returns to 0 so stream 0 wins next.
    setSources(32, 23, 0, 0);
    driveSources();
    pushBurst(0, 0, 16);
    pushBurst(1, 0, 7);
    runUntilDrained("pre_reset", 100);
    reset = 1'b0;
    @(negedge clk);
    monitor();
    checkOutput("reset_cycle_quiet", {req_ack, dout_vld}, '0);
    @(posedge clk);
    #1;
    advanceSources();
    reset = 1'b1;
    driveSources();
    @(negedge clk);
    monitor();
    checkOutput("after_reset_outputs", {req_ack, dout, dout_vld, grant_idx, busy}, '0);
    @(posedge clk);
    #1;
    advanceSources();
    driveSources();
    pushBurst(0, 16, 16);
    pushBurst(1, 7, 16);
    runUntilDrained("post_reset", 100);
    checkOutput("stream1_words", seq[1], 23);
    repeat (3) stepCycle();

`ifdef LEAF_ARB_HDR_EN
    // Lone stream 3: header word 0xC0DE0003, then a full 16-word payload burst.
    setSources(0, 0, 0, 16);
    driveSources();
    pushBurst(3, 0, 16);
    runUntilDrained("hdr_burst", 60);
    checkOutput("stream3_words", seq[3], 16);
    repeat (2) stepCycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
